axi_burst_test_master: RTL and testbench
========================================

// Module: axi_burst_test_master
// PURPOSE
//  AXI4 master driving axi_simple_dual_port_ram directly (upstream neighbour, same clock).
//  On a start pulse: one INCR write burst of a generated pattern, wait for B, one INCR read burst
//  of the same region, compare every R beat. Reports done/error/err_count. Used for bring-up and
//  regression.
// PARAMETERS
//  AXI_DATA_WIDTH   64    data width in bits; multiple of 32, >= 32
//  AXI_ID_WIDTH     8     ID width
//  AXI_ADDR_WIDTH   12    address width; must match slave
//  TIMEOUT_CYCLES   1024  max cycles in any wait state before abort; 0 = watchdog disabled
// PORTS
//  axi_clk         in   1     clock
//  axi_resetn      in   1     asynchronous active-low reset
//  start           in   1     1-cycle start pulse; ignored while busy
//  cfg_addr        in   AW    burst start address, sampled at start
//  cfg_len         in   8     AXI len (beats-1), sampled at start
//  cfg_id          in   IDW   ID used on AW and AR, sampled at start
//  cfg_seed        in   32    pattern seed, sampled at start
//  busy            out  1     high from the cycle after start to DONE inclusive
//  done            out  1     1-cycle pulse in DONE
//  error           out  1     sticky until next start: err_count!=0 or timeout
//  err_count       out  16    saturating mismatch/protocol error count, cleared at start
//  timeout         out  1     sticky until next start: watchdog fired
//  axi_aw_* / axi_w_* / axi_b_* / axi_ar_* / axi_r_*   full AXI4 master side, mirrors slave ports
// BEHAVIOUR
//  Reset (async, axi_resetn=0): state=IDLE. All valids, busy, done, error, timeout = 0.
//   err_count=0. Address/ID/data outputs = 0. axi_b_ready and axi_r_ready are constant 1 at all
//   times, including reset: the slave pipeline stalls otherwise.
//  Reset mid-operation: abort immediately and return to IDLE; no recovery of the in-flight burst.
//  Fixed fields:
//   - burst = 2'b01 (INCR), size = log2(DW/8), strb = all ones.
//   - start address = cfg_addr with low log2(DW/8) bits forced to 0.
//  Pattern: beat i (0..len) = {DW/32{seed+i}}. 32-bit add, wraps mod 2^32.
//  FSM: IDLE -> AW -> W -> B -> AR -> R -> DONE -> IDLE
//   IDLE: start=1 -> latch cfg, clear err_count/error/timeout, go AW. busy=1 next cycle.
//   AW: aw_valid=1 with addr/len/id stable until aw_valid&&aw_ready, then go W. No W before the AW
//    handshake.
//   W: w_valid=1 and data = beat k. Advance k on w_valid&&w_ready. w_last=1 only on beat len.
//    On the last handshake, drop w_valid and go B.
//   B: wait for b_valid (ready is always 1).
//    - b_resp!=OKAY or b_id!=cfg_id -> err_count+1.
//    - Then go AR.
//   AR: ar_valid=1 with the same addr/len/id until handshake, then go R with beat counter=0.
//   R: each r_valid beat j:
//    - Compare r_data with beat j -> +1 on mismatch.
//    - Check r_id==cfg_id -> +1 on mismatch.
//    - Check r_last==(j==len) -> +1 on mismatch.
//    - Check r_resp==OKAY -> +1 on mismatch.
//    - At most one increment per beat, even if several checks fail.
//    - After beat len, go DONE.
//    - Extra R beats outside state R are ignored.
//   DONE: done=1 for one cycle, busy drops next cycle, go IDLE.
//  Watchdog: counter cleared on every state change.
//   - In AW/W/B/AR/R, if it reaches TIMEOUT_CYCLES: timeout=1, drop all valids, go DONE.
//   - The burst is abandoned; the slave may be left mid-burst and needs a reset.
//  err_count saturates at 16'hFFFF.
//  Address wrap past 2^AW within a burst is the slave's concern; no check here.
//  start in the same cycle as DONE is ignored; only IDLE accepts start.
// TESTING
//  1 len=0, addr=0x000, seed=0x1000_0000 -> one beat each way, w_last=r_last=1 on beat 0,
//    done pulse, err_count=0.
//  2 len=15, addr=0x100, seed=0xFFFF_FFF8 -> pattern wraps through 0 (beat 8 = 0x0), 16 beats
//    match, err_count=0.
//  3 Force one R beat's r_data bit 0 flipped (slave model) on len=3 -> err_count=1, error=1,
//    done still pulses.
//  4 Slave holds aw_ready=0 with TIMEOUT_CYCLES=16 -> timeout=1 after 16 cycles in AW,
//    aw_valid drops, done pulses.
//  5 Assert axi_resetn=0 during beat 5 of W (len=7) -> all valids 0 same cycle; after release
//    IDLE, busy=0, and a new start runs cleanly.
//  6 start pulsed while busy and in DONE cycle -> ignored; cfg changes mid-run do not alter
//    issued addr/len/id.

Source files
------------

// File: rtl/axi_burst_test_master.sv
// AXI4 bring-up master: writes one INCR burst of a seeded pattern, reads it back
// and counts mismatching or malformed responses, with a per-state watchdog.
module axi_burst_test_master #(
   parameter int AXI_DATA_WIDTH = 64,
   parameter int AXI_ID_WIDTH   = 8,
   parameter int AXI_ADDR_WIDTH = 12,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                        axi_clk,
   input  logic                        axi_resetn,
   input  logic                        start,
   input  logic [AXI_ADDR_WIDTH-1:0]   cfg_addr,
   input  logic [7:0]                  cfg_len,
   input  logic [AXI_ID_WIDTH-1:0]     cfg_id,
   input  logic [31:0]                 cfg_seed,
   output logic                        busy,
   output logic                        done,
   output logic                        error,
   output logic [15:0]                 err_count,
   output logic                        timeout,
   output logic [AXI_ID_WIDTH-1:0]     axi_aw_id,
   output logic [AXI_ADDR_WIDTH-1:0]   axi_aw_addr,
   output logic [7:0]                  axi_aw_len,
   output logic [2:0]                  axi_aw_size,
   output logic [1:0]                  axi_aw_burst,
   output logic                        axi_aw_valid,
   input  logic                        axi_aw_ready,
   output logic [AXI_DATA_WIDTH-1:0]   axi_w_data,
   output logic [AXI_DATA_WIDTH/8-1:0] axi_w_strb,
   output logic                        axi_w_last,
   output logic                        axi_w_valid,
   input  logic                        axi_w_ready,
   input  logic [AXI_ID_WIDTH-1:0]     axi_b_id,
   input  logic [1:0]                  axi_b_resp,
   input  logic                        axi_b_valid,
   output logic                        axi_b_ready,
   output logic [AXI_ID_WIDTH-1:0]     axi_ar_id,
   output logic [AXI_ADDR_WIDTH-1:0]   axi_ar_addr,
   output logic [7:0]                  axi_ar_len,
   output logic [2:0]                  axi_ar_size,
   output logic [1:0]                  axi_ar_burst,
   output logic                        axi_ar_valid,
   input  logic                        axi_ar_ready,
   input  logic [AXI_ID_WIDTH-1:0]     axi_r_id,
   input  logic [AXI_DATA_WIDTH-1:0]   axi_r_data,
   input  logic [1:0]                  axi_r_resp,
   input  logic                        axi_r_last,
   input  logic                        axi_r_valid,
   output logic                        axi_r_ready
);

   localparam int SIZE_LOG2 = $clog2(AXI_DATA_WIDTH / 8);
   localparam int WORDS     = AXI_DATA_WIDTH / 32;
   localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_MASK = ~AXI_ADDR_WIDTH'((1 << SIZE_LOG2) - 1);
   localparam bit          WD_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;

   typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_t;

   state_t                    state, state_n;
   logic [AXI_ADDR_WIDTH-1:0] addr_q;
   logic [7:0]                len_q;
   logic [AXI_ID_WIDTH-1:0]   id_q;
   logic [31:0]               seed_q;
   logic [7:0]                beat_q;
   logic [15:0]               err_q;
   logic                      timeout_q;
   logic [31:0]               wd_q;

   logic                      load_cfg, beat_adv, beat_clr, err_hit, wd_fire;
   logic                      last_beat, wait_state;
   logic [AXI_DATA_WIDTH-1:0] exp_data;

   assign last_beat  = (beat_q == len_q);
   assign wait_state = (state inside {S_AW, S_W, S_B, S_AR, S_R});
   assign exp_data   = {WORDS{seed_q + 32'(beat_q)}};

   always_comb begin
      // NOTE: every signal driven here gets a default first so no path can infer a latch.
      state_n  = state;
      load_cfg = 1'b0;
      beat_adv = 1'b0;
      beat_clr = 1'b0;
      err_hit  = 1'b0;
      wd_fire  = 1'b0;
      case (state)
         S_IDLE: if (start) begin
            state_n  = S_AW;
            load_cfg = 1'b1;
         end
         S_AW: if (axi_aw_ready) state_n = S_W;
         S_W: if (axi_w_ready) begin
            beat_adv = 1'b1;
            if (last_beat) state_n = S_B;
         end
         S_B: if (axi_b_valid) begin
            err_hit = (axi_b_resp != 2'b00) || (axi_b_id != id_q);
            state_n = S_AR;
         end
         S_AR: if (axi_ar_ready) begin
            beat_clr = 1'b1;
            state_n  = S_R;
         end
         S_R: if (axi_r_valid) begin
            beat_adv = 1'b1;
            // Several failing checks on one beat still count as a single error.
            err_hit  = (axi_r_data != exp_data) || (axi_r_id != id_q) ||
                       (axi_r_last != last_beat) || (axi_r_resp != 2'b00);
            if (last_beat) state_n = S_DONE;
         end
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
      // A handshake completing in the expiry cycle wins over the watchdog.
      if (WD_EN && wait_state && (wd_q == WD_LAST) && (state_n == state)) begin
         wd_fire = 1'b1;
         state_n = S_DONE;
      end
   end

   always_ff @(posedge axi_clk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         state     <= S_IDLE;
         addr_q    <= '0;
         len_q     <= '0;
         id_q      <= '0;
         seed_q    <= '0;
         beat_q    <= '0;
         err_q     <= '0;
         timeout_q <= 1'b0;
         wd_q      <= '0;
      end else begin
         // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
         state <= state_n;
         wd_q  <= (state_n != state) ? 32'd0 : wd_q + 32'd1;
         if (load_cfg) begin
            addr_q    <= cfg_addr & ADDR_MASK;
            len_q     <= cfg_len;
            id_q      <= cfg_id;
            seed_q    <= cfg_seed;
            beat_q    <= '0;
            err_q     <= '0;
            timeout_q <= 1'b0;
         end else begin
            if (beat_adv)      beat_q <= beat_q + 8'd1;
            else if (beat_clr) beat_q <= '0;
            if (err_hit && (err_q != 16'hFFFF)) err_q <= err_q + 16'd1;
            if (wd_fire) timeout_q <= 1'b1;
         end
      end
   end

   // Valids decode straight from state so an asynchronous reset drops them at once.
   assign busy         = (state != S_IDLE);
   assign done         = (state == S_DONE);
   assign error        = (err_q != 16'd0) || timeout_q;
   assign err_count    = err_q;
   assign timeout      = timeout_q;

   assign axi_aw_id    = id_q;
   assign axi_aw_addr  = addr_q;
   assign axi_aw_len   = len_q;
   assign axi_aw_size  = 3'(SIZE_LOG2);
   assign axi_aw_burst = 2'b01;
   assign axi_aw_valid = (state == S_AW);

   assign axi_w_data   = exp_data;
   assign axi_w_strb   = '1;
   assign axi_w_valid  = (state == S_W);
   assign axi_w_last   = axi_w_valid && last_beat;
   assign axi_b_ready  = 1'b1;

   assign axi_ar_id    = id_q;
   assign axi_ar_addr  = addr_q;
   assign axi_ar_len   = len_q;
   assign axi_ar_size  = 3'(SIZE_LOG2);
   assign axi_ar_burst = 2'b01;
   assign axi_ar_valid = (state == S_AR);
   assign axi_r_ready  = 1'b1;

endmodule

// File: tb/tb_axi_burst_test_master.sv
// Directed bench for axi_burst_test_master with a small behavioural RAM slave
// that can stall AW and corrupt a chosen read beat.
module tb_axi_burst_test_master;

   localparam int DW  = 64;
   localparam int IDW = 8;
   localparam int AW  = 12;
   localparam int TO  = 16;

   logic axi_clk = 1'b0;
   logic axi_resetn = 1'b0;
   always #5 axi_clk = ~axi_clk;

   logic           start = 1'b0;
   logic [AW-1:0]  cfg_addr = '0;
   logic [7:0]     cfg_len = '0;
   logic [IDW-1:0] cfg_id = '0;
   logic [31:0]    cfg_seed = '0;
   logic           busy, done, error, timeout;
   logic [15:0]    err_count;
   logic [IDW-1:0] aw_id, ar_id, b_id, r_id;
   logic [AW-1:0]  aw_addr, ar_addr;
   logic [7:0]     aw_len, ar_len;
   logic [2:0]     aw_size, ar_size;
   logic [1:0]     aw_burst, ar_burst, b_resp, r_resp;
   logic           aw_valid, aw_ready, w_last, w_valid, w_ready, b_valid, b_ready;
   logic           ar_valid, ar_ready, r_last, r_valid, r_ready;
   logic [DW-1:0]  w_data, r_data;
   logic [DW/8-1:0] w_strb;

   axi_burst_test_master #(
      .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IDW), .AXI_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .axi_clk(axi_clk), .axi_resetn(axi_resetn), .start(start),
      .cfg_addr(cfg_addr), .cfg_len(cfg_len), .cfg_id(cfg_id), .cfg_seed(cfg_seed),
      .busy(busy), .done(done), .error(error), .err_count(err_count), .timeout(timeout),
      .axi_aw_id(aw_id), .axi_aw_addr(aw_addr), .axi_aw_len(aw_len), .axi_aw_size(aw_size),
      .axi_aw_burst(aw_burst), .axi_aw_valid(aw_valid), .axi_aw_ready(aw_ready),
      .axi_w_data(w_data), .axi_w_strb(w_strb), .axi_w_last(w_last), .axi_w_valid(w_valid),
      .axi_w_ready(w_ready),
      .axi_b_id(b_id), .axi_b_resp(b_resp), .axi_b_valid(b_valid), .axi_b_ready(b_ready),
      .axi_ar_id(ar_id), .axi_ar_addr(ar_addr), .axi_ar_len(ar_len), .axi_ar_size(ar_size),
      .axi_ar_burst(ar_burst), .axi_ar_valid(ar_valid), .axi_ar_ready(ar_ready),
      .axi_r_id(r_id), .axi_r_data(r_data), .axi_r_resp(r_resp), .axi_r_last(r_last),
      .axi_r_valid(r_valid), .axi_r_ready(r_ready)
   );

   // ---------------- slave model ----------------
   logic           aw_ready_en = 1'b1;
   logic [8:0]     flip_beat = 9'h1FF;
   logic [DW-1:0]  mem [0:511];
   logic [8:0]     wr_ptr, rd_ptr;
   logic [7:0]     rd_cnt, rd_len;
   logic [IDW-1:0] s_wid, s_rid;
   logic           r_active;

   assign aw_ready = aw_ready_en;
   assign w_ready  = 1'b1;
   assign ar_ready = 1'b1;
   assign b_resp   = 2'b00;
   assign b_id     = s_wid;
   assign r_resp   = 2'b00;
   assign r_id     = s_rid;
   assign r_valid  = r_active;
   assign r_last   = r_active && (rd_cnt == rd_len);
   assign r_data   = mem[rd_ptr] ^ (({1'b0, rd_cnt} == flip_beat) ? 64'd1 : 64'd0);

   always @(posedge axi_clk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         wr_ptr <= '0; rd_ptr <= '0; rd_cnt <= '0; rd_len <= '0;
         s_wid <= '0; s_rid <= '0; b_valid <= 1'b0; r_active <= 1'b0;
      end else begin
         if (aw_valid && aw_ready) begin
            wr_ptr <= aw_addr[11:3];
            s_wid  <= aw_id;
         end
         if (b_valid && b_ready) b_valid <= 1'b0;
         if (w_valid && w_ready) begin
            mem[wr_ptr] <= w_data;
            wr_ptr      <= wr_ptr + 9'd1;
            if (w_last) b_valid <= 1'b1;
         end
         if (ar_valid && ar_ready) begin
            rd_ptr <= ar_addr[11:3]; rd_len <= ar_len; rd_cnt <= '0;
            s_rid <= ar_id; r_active <= 1'b1;
         end
         if (r_valid && r_ready) begin
            rd_ptr <= rd_ptr + 9'd1;
            rd_cnt <= rd_cnt + 8'd1;
            if (rd_cnt == rd_len) r_active <= 1'b0;
         end
      end
   end

   // ---------------- bus monitor ----------------
   int             aw_cyc = 0, aw_hs = 0, ar_hs = 0, w_total = 0, r_total = 0, done_total = 0;
   logic [DW-1:0]  wlog [0:255];
   logic           wlast_log [0:255];
   logic           rlast_log [0:255];
   logic [AW-1:0]  mon_aw_addr = '0, mon_ar_addr = '0;
   logic [7:0]     mon_aw_len = '0, mon_ar_len = '0;
   logic [IDW-1:0] mon_aw_id = '0, mon_ar_id = '0;

   always @(posedge axi_clk) begin
      if (aw_valid) aw_cyc <= aw_cyc + 1;
      if (aw_valid && aw_ready) begin
         aw_hs <= aw_hs + 1; mon_aw_addr <= aw_addr; mon_aw_len <= aw_len; mon_aw_id <= aw_id;
      end
      if (ar_valid && ar_ready) begin
         ar_hs <= ar_hs + 1; mon_ar_addr <= ar_addr; mon_ar_len <= ar_len; mon_ar_id <= ar_id;
      end
      if (w_valid && w_ready) begin
         wlog[w_total] <= w_data; wlast_log[w_total] <= w_last; w_total <= w_total + 1;
      end
      if (r_valid && r_ready) begin
         rlast_log[r_total] <= r_last; r_total <= r_total + 1;
      end
      if (done) done_total <= done_total + 1;
   end

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic pulse_start(input logic [AW-1:0] a, input logic [7:0] l,
                              input logic [IDW-1:0] id, input logic [31:0] s);
      @(negedge axi_clk);
      start = 1'b1; cfg_addr = a; cfg_len = l; cfg_id = id; cfg_seed = s;
      @(negedge axi_clk);
      start = 1'b0;
   endtask

   // Leaves the caller at the negedge where done is high.
   task automatic wait_done(input string tag);
      bit ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (done) begin ok = 1'b1; break; end
         @(negedge axi_clk);
      end
      check({tag, "_done"}, 64'(ok), 64'd1);
   endtask

   task automatic run(input string tag, input logic [AW-1:0] a, input logic [7:0] l,
                      input logic [IDW-1:0] id, input logic [31:0] s);
      pulse_start(a, l, id, s);
      wait_done(tag);
      @(negedge axi_clk);
   endtask

   initial begin
      #500000;
      $display("FAIL global_time_limit");
      $fatal(1);
   end

   initial begin
      int wb, rb, db, ab, hb, arb, bad;
      logic [31:0] s;
      logic [63:0] exp_w;

      // ---- reset values ----
      repeat (3) @(negedge axi_clk);
      check("rst_valids", {aw_valid, w_valid, ar_valid, w_last}, 0);
      check("rst_readys", {b_ready, r_ready}, 2'b11);
      check("rst_status", {busy, done, error, timeout}, 0);
      check("rst_err_count", err_count, 0);
      check("rst_addr_id_len", {aw_addr, aw_id, aw_len}, 0);
      check("rst_wdata", w_data, 0);
      axi_resetn = 1'b1;
      @(negedge axi_clk);

      // ---- 1: single beat ----
      wb = w_total; rb = r_total; db = done_total;
      run("t1", 12'h000, 8'd0, 8'h01, 32'h1000_0000);
      check("t1_wbeats", 64'(w_total - wb), 1);
      check("t1_wdata", wlog[wb], 64'h1000_0000_1000_0000);
      check("t1_wlast", 64'(wlast_log[wb]), 1);
      check("t1_rbeats", 64'(r_total - rb), 1);
      check("t1_rlast", 64'(rlast_log[rb]), 1);
      check("t1_err_count", err_count, 0);
      check("t1_done_pulses", 64'(done_total - db), 1);
      check("t1_busy_after", 64'(busy), 0);
      check("t1_size_burst_strb", {aw_size, aw_burst, ar_size, ar_burst, w_strb}, {3'd3, 2'b01, 3'd3, 2'b01, 8'hFF});

      // ---- 2: 16 beats, pattern wraps through zero ----
      wb = w_total; rb = r_total;
      run("t2", 12'h100, 8'd15, 8'h22, 32'hFFFF_FFF8);
      check("t2_wbeats", 64'(w_total - wb), 16);
      check("t2_beat8", wlog[wb + 8], 64'h0);
      check("t2_beat15", wlog[wb + 15], 64'h0000_0007_0000_0007);
      bad = 0;
      for (int i = 0; i < 16; i++) begin
         s = 32'hFFFF_FFF8 + 32'(i);
         exp_w = {s, s};
         if (wlog[wb + i] !== exp_w) bad++;
         if (wlast_log[wb + i] !== (i == 15)) bad++;
         if (rlast_log[rb + i] !== (i == 15)) bad++;
      end
      check("t2_pattern_last", 64'(bad), 0);
      check("t2_rbeats", 64'(r_total - rb), 16);
      check("t2_err", {err_count, error}, 0);
      check("t2_aw", {mon_aw_addr, mon_aw_len, mon_aw_id}, {12'h100, 8'd15, 8'h22});

      // ---- 3: one corrupted read beat, unaligned address ----
      flip_beat = 9'd2;
      run("t3", 12'h047, 8'd3, 8'h33, 32'hDEAD_0000);
      flip_beat = 9'h1FF;
      check("t3_err_count", err_count, 1);
      check("t3_error_timeout", {error, timeout}, 2'b10);
      check("t3_addr_aligned", {mon_aw_addr, mon_ar_addr}, {12'h040, 12'h040});

      // ---- 4: AW stall trips watchdog ----
      aw_ready_en = 1'b0;
      ab = aw_cyc; wb = w_total;
      run("t4", 12'h200, 8'd3, 8'h44, 32'h0);
      aw_ready_en = 1'b1;
      check("t4_aw_cycles", 64'(aw_cyc - ab), 16);
      check("t4_timeout_error", {timeout, error}, 2'b11);
      check("t4_err_count", err_count, 0);
      check("t4_valids_dropped", {aw_valid, w_valid, ar_valid}, 0);
      check("t4_no_wbeats", 64'(w_total - wb), 0);

      // ---- 5: reset during W beat 5 ----
      wb = w_total;
      pulse_start(12'h300, 8'd7, 8'h55, 32'hA5A5_0000);
      bad = 1;
      for (int i = 0; i < 100; i++) begin
         if (w_valid && (w_total - wb) == 5) begin bad = 0; break; end
         @(negedge axi_clk);
      end
      check("t5_reached_beat5", 64'(bad), 0);
      axi_resetn = 1'b0;
      #1;
      check("t5_rst_valids", {aw_valid, w_valid, ar_valid, w_last}, 0);
      check("t5_rst_busy", 64'(busy), 0);
      repeat (2) @(negedge axi_clk);
      axi_resetn = 1'b1;
      @(negedge axi_clk);
      check("t5_idle_after", {busy, done, timeout}, 0);
      wb = w_total;
      run("t5_rerun", 12'h300, 8'd7, 8'h55, 32'h0000_0005);
      check("t5_rerun_err", {err_count, error, timeout}, 0);
      check("t5_rerun_wbeats", 64'(w_total - wb), 8);
      check("t5_rerun_beat7", wlog[wb + 7], 64'h0000_000C_0000_000C);

      // ---- 6: start while busy / in DONE, cfg changes mid-run ----
      hb = aw_hs; arb = ar_hs; db = done_total;
      pulse_start(12'h208, 8'd3, 8'h5A, 32'h0000_1234);
      repeat (2) @(negedge axi_clk);
      check("t6_busy_during", 64'(busy), 1);
      start = 1'b1; cfg_addr = 12'h3F0; cfg_len = 8'd9; cfg_id = 8'h11; cfg_seed = 32'h0;
      @(negedge axi_clk);
      start = 1'b0;
      wait_done("t6");
      start = 1'b1;
      @(negedge axi_clk);
      start = 1'b0;
      check("t6_idle_after_done", 64'(busy), 0);
      repeat (4) @(negedge axi_clk);
      check("t6_still_idle", 64'(busy), 0);
      check("t6_handshakes", {32'(aw_hs - hb), 32'(ar_hs - arb)}, {32'd1, 32'd1});
      check("t6_done_pulses", 64'(done_total - db), 1);
      check("t6_aw_fields", {mon_aw_addr, mon_aw_len, mon_aw_id}, {12'h208, 8'd3, 8'h5A});
      check("t6_ar_fields", {mon_ar_addr, mon_ar_len, mon_ar_id}, {12'h208, 8'd3, 8'h5A});
      check("t6_err_count", err_count, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
